sprite_blitter: RTL and testbench

// - Writer side of the sprite path: copies one palette-indexed sprite from its synchronous ROM into the

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/blit_xy_counter.sv | 42 ++++
 rtl/sprite_blitter.sv | 135 +++++++++++++
 tb/tb_sprite_blitter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and default geometry for the sprite blit path.
package sprite_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} blit_state_t;

  localparam int unsigned SPR_W_DEF           = 68;
  localparam int unsigned SPR_H_DEF           = 64;
  localparam int unsigned FB_W_DEF            = 320;
  localparam int unsigned FB_H_DEF            = 240;
  localparam int unsigned IDX_W_DEF           = 4;
  localparam int unsigned TRANSPARENT_IDX_DEF = 0;

  // Screen-coordinate sums are carried wide enough that pos + offset never wraps.
  localparam int unsigned SUM_W = 11;

  function automatic int unsigned addr_w(input int unsigned w, input int unsigned h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blit_xy_counter.sv
// Raster col/row counter: col runs fastest, wraps into row; last flags the final pixel.
module blit_xy_counter
  import sprite_pkg::*;
#(
  parameter int unsigned W     = SPR_W_DEF,
  parameter int unsigned H     = SPR_H_DEF,
  parameter int unsigned COL_W = cnt_w(W),
  parameter int unsigned ROW_W = cnt_w(H)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             en,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  logic col_end, row_end;

  assign col_end = (col == COL_W'(W - 1));
  assign row_end = (row == ROW_W'(H - 1));
  assign last    = col_end && row_end;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// Copies one palette-indexed sprite ROM into the framebuffer, skipping transparent and off-screen
// pixels. Define SPRITE_BLIT_MIRROR_EN to add the mirror_x horizontal-flip input.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W           = SPR_W_DEF,
  parameter int unsigned SPR_H           = SPR_H_DEF,
  parameter int unsigned FB_W            = FB_W_DEF,
  parameter int unsigned FB_H            = FB_H_DEF,
  parameter int unsigned IDX_W           = IDX_W_DEF,
  parameter int unsigned TRANSPARENT_IDX = TRANSPARENT_IDX_DEF,
  localparam int unsigned ROM_AW         = addr_w(SPR_W, SPR_H),
  localparam int unsigned FB_AW          = addr_w(FB_W, FB_H)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
`ifdef SPRITE_BLIT_MIRROR_EN
  input  logic              mirror_x,
`endif
  output logic              busy,
  output logic              done,
  output logic [ROM_AW-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic              fb_we,
  output logic [FB_AW-1:0]  fb_addr,
  output logic [IDX_W-1:0]  fb_data
);

  localparam int unsigned COL_W = cnt_w(SPR_W);
  localparam int unsigned ROW_W = cnt_w(SPR_H);

  blit_state_t state_q, state_d;
  logic             accept, cnt_clear, cnt_en, cnt_last;
  logic [COL_W-1:0] col, rd_col, s1_col;
  logic [ROW_W-1:0] row, s1_row;
  logic             s1_valid;
  logic [9:0]       pos_x_q, pos_y_q;
  logic             mirror_q;
  logic [SUM_W-1:0] x_sum, y_sum;
  logic             on_screen;

  assign accept = (state_q == IDLE) && start;

  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          cnt_clear = 1'b1;
        end
      end
      FETCH: begin
        cnt_en = 1'b1;
        if (cnt_last) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign busy = (state_q == FETCH) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
    end else if (accept) begin
      pos_x_q <= pos_x;
      pos_y_q <= pos_y;
    end
  end

`ifdef SPRITE_BLIT_MIRROR_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)       mirror_q <= 1'b0;
    else if (accept) mirror_q <= mirror_x;
  end
`else
  assign mirror_q = 1'b0;
`endif

  blit_xy_counter #(
    .W     (SPR_W),
    .H     (SPR_H),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_xy (
    .Clk   (Clk),
    .Reset (Reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .col   (col),
    .row   (row),
    .last  (cnt_last)
  );

  // Mirroring only changes which ROM column is read; FB placement follows the unflipped col.
  assign rd_col      = mirror_q ? (COL_W'(SPR_W - 1) - col) : col;
  assign rom_address = ROM_AW'(row) * ROM_AW'(SPR_W) + ROM_AW'(rd_col);

  // Stage 1 aligns pixel coordinates with rom_q, which arrives one cycle after its address.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_col   <= '0;
      s1_row   <= '0;
    end else begin
      s1_valid <= (state_q == FETCH);
      s1_col   <= col;
      s1_row   <= row;
    end
  end

  assign x_sum     = SUM_W'(pos_x_q) + SUM_W'(s1_col);
  assign y_sum     = SUM_W'(pos_y_q) + SUM_W'(s1_row);
  assign on_screen = (x_sum < SUM_W'(FB_W)) && (y_sum < SUM_W'(FB_H));

  assign fb_we   = s1_valid && (rom_q != IDX_W'(TRANSPARENT_IDX)) && on_screen;
  assign fb_addr = fb_we ? (FB_AW'(y_sum) * FB_AW'(FB_W) + FB_AW'(x_sum)) : '0;
  assign fb_data = fb_we ? rom_q : '0;

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter; mirror scenario runs when SPRITE_BLIT_MIRROR_EN is defined.
module tb_sprite_blitter;

  localparam int SW = 68;
  localparam int SH = 64;
  localparam int N  = SW * SH;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [9:0]  pos_x, pos_y;
`ifdef SPRITE_BLIT_MIRROR_EN
  logic        mirror_x;
`endif
  logic        busy, done;
  logic [12:0] rom_address;
  logic [3:0]  rom_q;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [3:0]  fb_data;

  int pat = 0;
  int passed = 0;
  int total = 0;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t sb[$];

  sprite_blitter dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
`ifdef SPRITE_BLIT_MIRROR_EN
    .mirror_x    (mirror_x),
`endif
    .busy        (busy),
    .done        (done),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .fb_we       (fb_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data)
  );

  always #5 Clk = ~Clk;

  function automatic int pix(input int p, input int r, input int c);
    case (p)
      0:       return 5;
      1:       return ((r + c) % 2 == 1) ? 7 : 0;
      default: return (r * 3 + c) % 16;
    endcase
  endfunction

  // Synchronous sprite ROM: data for an address appears one cycle later.
  always @(posedge Clk) begin
    rom_q <= 4'(pix(pat, int'(rom_address) / SW, int'(rom_address) % SW));
  end

  task automatic run_blit(input string name, input int px, input int py, input int p,
                          input int m, input int restart);
    int  busy_cyc = 0;
    int  done_cnt = 0;
    int  done_at  = -1;
    int  n_wr     = 0;
    int  n_exp;
    wr_t e;
    pat = p;
    sb.delete();
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        int d, x, y;
        d = pix(p, r, (m != 0) ? (SW - 1 - c) : c);
        x = px + c;
        y = py + r;
        if (d != 0 && x < 320 && y < 240) sb.push_back('{y * 320 + x, d});
      end
    end
    n_exp = sb.size();
    @(negedge Clk);
    pos_x = 10'(px);
    pos_y = 10'(py);
`ifdef SPRITE_BLIT_MIRROR_EN
    mirror_x = (m != 0);
`endif
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    for (int c = 1; c <= N + 4; c++) begin
      if (c == 1) begin
        total++;
        if (rom_address !== 13'((m != 0) ? SW - 1 : 0))
          $display("FAIL %s first_rom_addr got=%0d want=%0d", name, rom_address,
                   (m != 0) ? SW - 1 : 0);
        else passed++;
      end
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        done_at = c;
      end
      if (fb_we) begin
        n_wr++;
        total++;
        if (sb.size() == 0) begin
          $display("FAIL %s unexpected_write cycle=%0d addr=%0d data=%0d", name, c, fb_addr,
                   fb_data);
        end else begin
          e = sb.pop_front();
          if (fb_addr !== e.addr[16:0] || fb_data !== e.data[3:0])
            $display("FAIL %s write cycle=%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                     name, c, fb_addr, fb_data, e.addr, e.data);
          else passed++;
        end
      end
      if (restart != 0) begin
        start = (c == 100) || (c == N + 2);
        pos_x = 10'd5;
        pos_y = 10'd7;
      end
      @(negedge Clk);
    end
    start = 1'b0;
    total++;
    if (busy_cyc !== N + 1) $display("FAIL %s busy_cycles got=%0d want=%0d", name, busy_cyc, N + 1);
    else passed++;
    total++;
    if (done_cnt !== 1) $display("FAIL %s done_count got=%0d want=1", name, done_cnt);
    else passed++;
    total++;
    if (done_at !== N + 2) $display("FAIL %s done_cycle got=%0d want=%0d", name, done_at, N + 2);
    else passed++;
    total++;
    if (n_wr !== n_exp) $display("FAIL %s write_count got=%0d want=%0d", name, n_wr, n_exp);
    else passed++;
    total++;
    if (sb.size() !== 0) $display("FAIL %s missing_writes got=%0d want=0", name, sb.size());
    else passed++;
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if ({busy, done, fb_we} !== 3'b000 || rom_address !== 13'd0 || fb_addr !== 17'd0 ||
        fb_data !== 4'd0)
      $display("FAIL %s outputs got busy=%b done=%b we=%b rom=%0d addr=%0d data=%0d want all 0",
               name, busy, done, fb_we, rom_address, fb_addr, fb_data);
    else passed++;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    start = 1'b0;
    pos_x = '0;
    pos_y = '0;
`ifdef SPRITE_BLIT_MIRROR_EN
    mirror_x = 1'b0;
`endif
    repeat (3) @(negedge Clk);
    check_idle_outputs("reset");
    Reset = 1'b0;
    @(negedge Clk);
    check_idle_outputs("post_reset");
  endtask

  task automatic test_reset_abort();
    int done_cnt = 0;
    int we_cnt   = 0;
    pat = 0;
    @(negedge Clk);
    pos_x = 10'd10;
    pos_y = 10'd10;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    for (int c = 1; c < 2000; c++) @(negedge Clk);
    total++;
    if (busy !== 1'b1 || fb_we !== 1'b1)
      $display("FAIL abort_pre busy=%b we=%b want 1 1", busy, fb_we);
    else passed++;
    Reset = 1'b1;
    #1;
    check_idle_outputs("abort_immediate");
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      if (done) done_cnt++;
      if (fb_we) we_cnt++;
    end
    Reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      if (done) done_cnt++;
      if (fb_we) we_cnt++;
    end
    total++;
    if (done_cnt !== 0 || we_cnt !== 0)
      $display("FAIL abort_quiet done=%0d writes=%0d want 0 0", done_cnt, we_cnt);
    else passed++;
    run_blit("after_abort", 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    run_blit("basic", 0, 0, 0, 0, 0);
    run_blit("checker", 0, 0, 1, 0, 0);
    run_blit("clip", 300, 200, 0, 0, 0);
    run_blit("offscreen", 320, 0, 1, 0, 0);
    run_blit("ignored_start", 40, 30, 2, 0, 1);
    test_reset_abort();
`ifdef SPRITE_BLIT_MIRROR_EN
    run_blit("mirror", 0, 0, 2, 1, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
